// File: rtl/pe_conf_seq.sv
// pe_conf_seq: streams weight words serially into a daisy-chained PE array, then strobes the control values into every PE.
module pe_conf_seq #(
  parameter int NUM_PE = 4,
  parameter int M = 4,
  parameter int CL_IN = 4,
  parameter int CL1 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CL_IN-1:0] cfg_bp_ch,
  input  logic [CL_IN-1:0] cfg_d_ch,
  input  logic [CL1-1:0]   cfg_bp_src,
  input  logic             wv_valid,
  input  logic [M-1:0]     wv_data,
  output logic             wv_ready,
  output logic [M-1:0]     w_in_o,
  output logic             w_conf_o,
  output logic             cntl_conf_o,
  output logic [CL_IN-1:0] bp_ch_o,
  output logic [CL_IN-1:0] d_ch_o,
  output logic [CL1-1:0]   bp_src_o,
  input  logic [CL_IN-1:0] en_in,
  output logic [CL_IN-1:0] en_out,
  output logic             busy,
  output logic             cfg_valid,
  output logic             done
);
  localparam int NW = 9 * NUM_PE;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, CNTL, WAIT, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic xfer, go, last;
  assign wv_ready = state == LOAD_W;
  assign xfer = wv_valid & wv_ready;
  assign go = start & (state == IDLE || state == RUN);
  assign last = cnt == CW'(NW - 1);
  assign cntl_conf_o = state == WAIT;
  assign busy = state inside {LOAD_W, CNTL, WAIT};
  assign en_out = en_in & {CL_IN{cfg_valid}};
  always_comb begin
    state_n = go ? LOAD_W :
              (state == LOAD_W && xfer && last) ? CNTL :
              state == CNTL ? WAIT :
              state == WAIT ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      w_in_o    <= '0;
      w_conf_o  <= 1'b0;
      bp_ch_o   <= '0;
      d_ch_o    <= '0;
      bp_src_o  <= '0;
      cfg_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_n;
      w_conf_o <= xfer;
      done     <= state == WAIT;
      if (xfer) begin
        w_in_o <= wv_data;
        cnt    <= last ? '0 : cnt + 1'b1;
      end
      // control values stay frozen from the start latch until the next restart
      if (go) begin
        cnt       <= '0;
        bp_ch_o   <= cfg_bp_ch;
        d_ch_o    <= cfg_d_ch;
        bp_src_o  <= cfg_bp_src;
        cfg_valid <= 1'b0;
      end else if (state == WAIT) begin
        cfg_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pe_conf_seq.sv
// tb_pe_conf_seq: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_pe_conf_seq;
  localparam int NUM_PE = 2, M = 8, CL_IN = 4, CL1 = 2, NW = 18;
  logic clk = 0, rst = 1, start = 0, wv_valid = 0;
  logic [CL_IN-1:0] cfg_bp_ch = '0, cfg_d_ch = '0, en_in = 4'b1111;
  logic [CL1-1:0] cfg_bp_src = '0;
  logic [M-1:0] wv_data = '0;
  logic wv_ready, w_conf_o, cntl_conf_o, busy, cfg_valid, done;
  logic [M-1:0] w_in_o;
  logic [CL_IN-1:0] bp_ch_o, d_ch_o, en_out;
  logic [CL1-1:0] bp_src_o;
  int total = 0, bad = 0, cyc = 0, last_xfer = -100, cntl_cyc = -100, wcnt = 0, n_done = 0;
  logic prev_xfer = 0;
  logic [M-1:0] exp_w[$];
  logic [9:0] exp_cfg[$];

  pe_conf_seq #(.NUM_PE(NUM_PE), .M(M), .CL_IN(CL_IN), .CL1(CL1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bp_ch(cfg_bp_ch), .cfg_d_ch(cfg_d_ch),
    .cfg_bp_src(cfg_bp_src), .wv_valid(wv_valid), .wv_data(wv_data), .wv_ready(wv_ready),
    .w_in_o(w_in_o), .w_conf_o(w_conf_o), .cntl_conf_o(cntl_conf_o), .bp_ch_o(bp_ch_o),
    .d_ch_o(d_ch_o), .bp_src_o(bp_src_o), .en_in(en_in), .en_out(en_out), .busy(busy),
    .cfg_valid(cfg_valid), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // monitor: checks registered weight stream, control strobe and completion against the queues
  always @(negedge clk) begin
    chk("w_conf_o", w_conf_o, prev_xfer);
    if (w_conf_o) begin
      wcnt++;
      if (exp_w.size() == 0) begin
        total++; bad++;
        $display("FAIL w_in_o: got %0d want no word", w_in_o);
      end else chk("w_in_o", w_in_o, exp_w.pop_front());
    end
    if (busy) chk("en_out_busy", en_out, 0);
    if (cntl_conf_o) begin
      chk("cntl_timing", cyc, last_xfer + 2);
      chk("word_count", wcnt, NW);
      if (exp_cfg.size() == 0) begin
        total++; bad++;
        $display("FAIL cntl_conf_o: got pulse want none (cycle %0d)", cyc);
      end else chk("cfg_out", {bp_ch_o, d_ch_o, bp_src_o}, exp_cfg.pop_front());
      cntl_cyc = cyc;
      wcnt = 0;
    end
    if (done) begin
      n_done++;
      chk("done_timing", cyc, cntl_cyc + 1);
      chk("cfg_valid_done", cfg_valid, 1);
      chk("en_out_run", en_out, en_in);
    end
    prev_xfer = wv_valid & wv_ready & !rst;
    if (wv_valid & wv_ready) last_xfer = cyc;
    if (rst) wcnt = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] bp, input logic [3:0] d, input logic [1:0] src);
    start = 1; cfg_bp_ch = bp; cfg_d_ch = d; cfg_bp_src = src;
    exp_cfg.push_back({bp, d, src});
    tick();
    start = 0;
  endtask

  task automatic send(input int n, input bit gaps, input int ign_at);
    for (int i = 1; i <= n; i++) begin
      if (gaps) begin
        wv_valid = 0;
        tick();
      end
      wv_valid = 1;
      wv_data = M'(i);
      if (i == ign_at) begin
        start = 1; cfg_bp_ch = 4'b1111; cfg_d_ch = 4'b0000; cfg_bp_src = 2'b11;
      end
      @(negedge clk);
      for (int b = 0; !wv_ready; b++) begin
        if (b == 20) abort("wv_ready_timeout");
        @(negedge clk);
      end
      exp_w.push_back(M'(i));
      tick();
      start = 0;
    end
    wv_valid = 0;
  endtask

  task automatic wait_done(input int want);
    for (int b = 0; n_done < want; b++) begin
      if (b == 20) abort("done_timeout");
      @(negedge clk);
    end
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_in_o"}, w_in_o, 0);
    chk({tag, "_w_conf_o"}, w_conf_o, 0);
    chk({tag, "_cntl_conf_o"}, cntl_conf_o, 0);
    chk({tag, "_cfg_out"}, {bp_ch_o, d_ch_o, bp_src_o}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_valid"}, cfg_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wv_ready"}, wv_ready, 0);
    chk({tag, "_en_out"}, en_out, 0);
  endtask

  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 0;
    tick();
    // back-to-back load from IDLE
    do_start(4'b0101, 4'b1111, 2'b10);
    send(NW, 0, 0);
    wait_done(1);
    chk("bp_ch_run", bp_ch_o, 4'b0101);
    chk("cfg_valid_run", cfg_valid, 1);
    chk("en_out_idle_run", en_out, 4'b1111);
    chk("busy_run", busy, 0);
    // load with wv_valid low every other cycle
    do_start(4'b1010, 4'b0011, 2'b01);
    send(NW, 1, 0);
    wait_done(2);
    // start during LOAD_W at word 5 must be ignored
    do_start(4'b0110, 4'b1100, 2'b11);
    send(NW, 0, 5);
    wait_done(3);
    chk("bp_ch_after_ignored", bp_ch_o, 4'b0110);
    // reset after 9 words discards the partial load
    do_start(4'b1001, 4'b0101, 2'b00);
    send(9, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk_all_zero("midreset");
    chk("exp_w_drained", exp_w.size(), 0);
    exp_cfg.delete();
    repeat (4) tick();
    do_start(4'b1100, 4'b1010, 2'b01);
    send(NW, 0, 0);
    wait_done(4);
    // restart from RUN drops cfg_valid immediately
    do_start(4'b0011, 4'b1111, 2'b10);
    @(negedge clk);
    chk("restart_cfg_valid", cfg_valid, 0);
    chk("restart_en_out", en_out, 0);
    chk("restart_busy", busy, 1);
    chk("restart_bp_ch", bp_ch_o, 4'b0011);
    tick();
    send(NW, 0, 0);
    wait_done(5);
    chk("final_bp_ch", bp_ch_o, 4'b0011);
    chk("final_exp_w", exp_w.size(), 0);
    chk("final_exp_cfg", exp_cfg.size(), 0);
    chk("final_done_count", n_done, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    abort("global_timeout");
  end
endmodule

// File: doc/pe_conf_seq.md
PE_CONF_SEQ -- requirements
Module: pe_conf_seq

Interface
REQ-001 Parameter NUM_PE, default 4: number of daisy-chained PEs fed by this sequencer (weight chain w_out -> w_in).
REQ-002 Parameter M, default 4: weight width.
REQ-003 Parameter CL_IN, default 4: number of feature channels.
REQ-004 Parameter CL1, default 2: bypass-source select width.
REQ-005 Ports are listed below as name, direction, width, meaning.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle request to (re)configure the chain.
REQ-009 cfg_bp_ch  in  CL_IN  bypass-channel mask to program.
REQ-010 cfg_d_ch  in  CL_IN  enable-channel mask to program.
REQ-011 cfg_bp_src  in  CL1  bypass-source select to program.
REQ-012 wv_valid  in  1  weight word valid.
REQ-013 wv_data  in  M  weight word.
REQ-014 wv_ready  out  1  sequencer accepts a weight word.
REQ-015 w_in_o  out  M  serial weight to the first PE.
REQ-016 w_conf_o  out  1  weight-shift enable to all PEs.
REQ-017 cntl_conf_o  out  1  control-latch strobe to all PEs.
REQ-018 bp_ch_o / d_ch_o / bp_src_o  out  CL_IN / CL_IN / CL1  control values presented to the PE chain.
REQ-019 en_in  in  CL_IN  frame data-enable from upstream.
REQ-020 en_out  out  CL_IN  gated data-enable to the PE chain.
REQ-021 busy  out  1  configuration in progress.
REQ-022 cfg_valid  out  1  chain fully configured (level).
REQ-023 done  out  1  one-cycle pulse when configuration completes.

Function
REQ-024 The FSM SHALL have states IDLE, LOAD_W, CNTL, WAIT, RUN.
REQ-025 IDLE or RUN with start=1: latch cfg_* into bp_ch_o/d_ch_o/bp_src_o, clear the word counter, drop cfg_valid, go to LOAD_W.
REQ-026 start SHALL be ignored in LOAD_W, CNTL and WAIT.
REQ-027 wv_ready SHALL be 1 exactly while in LOAD_W (combinational from state).
REQ-028 Transfer = wv_valid & wv_ready; on a transfer in cycle t, w_in_o=wv_data and w_conf_o=1 in cycle t+1 (registered, latency 1).
REQ-029 In any cycle following a non-transfer, w_conf_o SHALL be 0 and w_in_o SHALL hold its last value (the chain stalls).
REQ-030 The word counter SHALL count transfers 0..9*NUM_PE-1; on the transfer at count 9*NUM_PE-1 (cycle t), go to CNTL (t+1).
REQ-031 cntl_conf_o SHALL be 1 in cycle t+2 only (WAIT), with bp_ch_o/d_ch_o/bp_src_o stable from the start latch through RUN.
REQ-032 In cycle t+3, enter RUN: cfg_valid=1 (held), done=1 for exactly one cycle.
REQ-033 busy SHALL be 1 in LOAD_W, CNTL and WAIT, otherwise 0.
REQ-034 en_out SHALL equal en_in & {CL_IN{cfg_valid}} (combinational).
REQ-035 A restart from RUN SHALL drop cfg_valid in the next cycle, forcing en_out to 0 for the entire reload.
REQ-036 The counter width SHALL be clog2(9*NUM_PE), and the counter SHALL not wrap before the terminal transfer.

Reset
REQ-037 rst=1 SHALL, at the next edge, force the state to IDLE, the counter to 0, and all outputs to 0 (w_in_o, w_conf_o, cntl_conf_o, bp_ch_o, d_ch_o, bp_src_o, busy, cfg_valid, done), regardless of current state.
REQ-038 A reset mid-LOAD_W SHALL discard partial weights; no cntl_conf_o pulse SHALL follow.

Verification
REQ-039 NUM_PE=2: start with cfg_bp_ch=4'b0101, cfg_d_ch=4'b1111, cfg_bp_src=2'b10; 18 back-to-back words 1..18 -> w_conf_o high 18 consecutive cycles carrying 1..18, cntl_conf_o pulses 2 cycles after the last transfer, done plus cfg_valid 1 cycle later, bp_ch_o=4'b0101.
REQ-040 Same, with wv_valid low every other cycle -> w_conf_o toggles in step with wv_valid, still exactly 18 high cycles, and correct ordering.
REQ-041 en_in=4'b1111 throughout -> en_out=0 until cfg_valid rises, then 4'b1111.
REQ-042 start asserted during LOAD_W at word 5 -> ignored; the sequence completes normally after 18 words.
REQ-043 rst asserted at word 10 -> next cycle all outputs 0, state IDLE; a new start reloads all 18 words.
REQ-044 Restart from RUN with new cfg_bp_ch=4'b0011 -> cfg_valid and en_out drop the next cycle, and bp_ch_o=4'b0011 appears at cntl_conf_o.
